// File: rtl/kyber_pack_pkg.sv
// Shared constants, FSM state type and configuration helpers for the Kyber
// ByteEncode_d streaming packer.
package kyber_pack_pkg;

  localparam int MAX_D   = 12;
  localparam int N_COEF  = 256;
  localparam int KYBER_Q = 3329;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  function automatic logic d_legal(input logic [3:0] d, input int max_d);
    return (d != 4'd0) && (int'(d) <= max_d);
  endfunction

  // 256 coefficients of d bits = 32*d bytes per polynomial.
  function automatic int beats_per_poly(input logic [3:0] d, input int out_bytes);
    return (32 * int'(d)) / out_bytes;
  endfunction

endpackage

// File: rtl/byte_encode_acc.sv
// Bit accumulator for byte_encode_stream: masks and inserts d-bit coefficients
// LSB-first above the current fill level, and drops one output word on shift.
module byte_encode_acc #(
  parameter int MAX_D     = 12,
  parameter int OUT_BYTES = 1,
  localparam int W        = 8 * OUT_BYTES,
  localparam int ACC_W    = W + MAX_D - 1,
  localparam int FW       = $clog2(ACC_W + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             ins_i,
  input  logic             shift_i,
  input  logic [3:0]       d_i,
  input  logic [MAX_D-1:0] coef_i,
  output logic [W-1:0]     data_o,
  output logic [FW-1:0]    fill_o
);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic [ACC_W-1:0] ins_word;

  function automatic logic [MAX_D-1:0] mask_d(input logic [3:0] d);
    logic [MAX_D-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_D; i++) m[i] = (i < int'(d));
    return m;
  endfunction

  // Insert only happens with fill < W, so the shifted coefficient always fits.
  always_comb begin
    ins_word = ACC_W'(coef_i & mask_d(d_i)) << fill_q;
    acc_d    = acc_q;
    fill_d   = fill_q;
    if (clr_i) begin
      acc_d  = '0;
      fill_d = '0;
    end else if (shift_i) begin
      acc_d  = acc_q >> W;
      fill_d = fill_q - FW'(W);
    end else if (ins_i) begin
      acc_d  = acc_q | ins_word;
      fill_d = fill_q + FW'(d_i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      fill_q <= '0;
    end else begin
      acc_q  <= acc_d;
      fill_q <= fill_d;
    end
  end

  assign data_o = acc_q[W-1:0];
  assign fill_o = fill_q;

endmodule

// File: rtl/byte_encode_stream.sv
// Streaming Kyber ByteEncode_d packer: one d-bit coefficient in per handshake,
// OUT_BYTES-wide words out. Define BYTE_ENCODE_RANGE_CHECK_EN for range_err.
module byte_encode_stream #(
  parameter int MAX_D     = kyber_pack_pkg::MAX_D,
  parameter int N_COEF    = kyber_pack_pkg::N_COEF,
  parameter int OUT_BYTES = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [3:0]             d_sel,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [MAX_D-1:0]       in_coef,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [8*OUT_BYTES-1:0] out_data,
  output logic                   out_last,
  output logic                   busy,
  output logic                   done,
  output logic                   cfg_err
`ifdef BYTE_ENCODE_RANGE_CHECK_EN
  ,
  output logic                   range_err
`endif
);
  import kyber_pack_pkg::*;

  localparam int W     = 8 * OUT_BYTES;
  localparam int ACC_W = W + MAX_D - 1;
  localparam int FW    = $clog2(ACC_W + 1);
  localparam int CW    = $clog2(N_COEF + 1);
  localparam int BW    = $clog2(32 * MAX_D + 1);

  state_e        state_q, state_d;
  logic [3:0]    d_q, d_d;
  logic [CW-1:0] coef_cnt_q, coef_cnt_d;
  logic [BW-1:0] beat_cnt_q, beat_cnt_d;
  logic          done_q, done_d;
  logic          cfg_err_q, cfg_err_d;

  logic          run, in_hs, out_hs, acc_clr, start_ok;
  logic [FW-1:0] fill;
  logic [BW-1:0] last_beat;

  byte_encode_acc #(
    .MAX_D    (MAX_D),
    .OUT_BYTES(OUT_BYTES)
  ) u_acc (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (acc_clr),
    .ins_i  (in_hs),
    .shift_i(out_hs),
    .d_i    (d_q),
    .coef_i (in_coef),
    .data_o (out_data),
    .fill_o (fill)
  );

  // Ready and valid are both decoded from registered state and are exclusive.
  assign run       = (state_q == RUN);
  assign in_ready  = run && (coef_cnt_q < CW'(N_COEF)) && (fill < FW'(W));
  assign out_valid = run && (fill >= FW'(W));
  assign last_beat = BW'(beats_per_poly(d_q, OUT_BYTES) - 1);
  assign out_last  = out_valid && (beat_cnt_q == last_beat);
  assign in_hs     = in_valid && in_ready;
  assign out_hs    = out_valid && out_ready;
  assign start_ok  = (state_q == IDLE) && start && d_legal(d_sel, MAX_D);
  assign busy      = run;
  assign done      = done_q;
  assign cfg_err   = cfg_err_q;

  always_comb begin
    state_d    = state_q;
    d_d        = d_q;
    coef_cnt_d = coef_cnt_q;
    beat_cnt_d = beat_cnt_q;
    done_d     = 1'b0;
    cfg_err_d  = 1'b0;
    acc_clr    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_ok) begin
          state_d    = RUN;
          d_d        = d_sel;
          coef_cnt_d = '0;
          beat_cnt_d = '0;
          acc_clr    = 1'b1;
        end else if (start) begin
          cfg_err_d = 1'b1;
        end
      end
      RUN: begin
        if (in_hs) coef_cnt_d = coef_cnt_q + CW'(1);
        if (out_hs) begin
          beat_cnt_d = beat_cnt_q + BW'(1);
          if (out_last) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      d_q        <= '0;
      coef_cnt_q <= '0;
      beat_cnt_q <= '0;
      done_q     <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      d_q        <= d_d;
      coef_cnt_q <= coef_cnt_d;
      beat_cnt_q <= beat_cnt_d;
      done_q     <= done_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

`ifdef BYTE_ENCODE_RANGE_CHECK_EN
  logic range_err_q, range_err_d;

  // d == 12 is the full-width Kyber case where values must lie below q.
  function automatic logic coef_bad(input logic [MAX_D-1:0] c, input logic [3:0] d);
    if (int'(d) == 12) return int'(c) >= KYBER_Q;
    return (c >> d) != '0;
  endfunction

  always_comb begin
    range_err_d = range_err_q;
    if (start_ok) range_err_d = 1'b0;
    else if (in_hs && coef_bad(in_coef, d_q)) range_err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) range_err_q <= 1'b0;
    else        range_err_q <= range_err_d;
  end

  assign range_err = range_err_q;
`endif

endmodule

// File: tb/tb_byte_encode_stream.sv
// Randomised bench for byte_encode_stream against a bit-list reference model.
module tb_byte_encode_stream;

  localparam int MAX_D = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic             start_a, iv_a, or_a;
  logic [3:0]       dsel_a;
  logic [MAX_D-1:0] coef_a;
  logic             ir_a, ov_a, last_a, busy_a, done_a, cerr_a;
  logic [7:0]       od_a;
  logic             start_b, iv_b, or_b;
  logic [3:0]       dsel_b;
  logic [MAX_D-1:0] coef_b;
  logic             ir_b, ov_b, last_b, busy_b, done_b, cerr_b;
  logic [31:0]      od_b;
`ifdef BYTE_ENCODE_RANGE_CHECK_EN
  logic             rerr_a, rerr_b;
`endif

  byte_encode_stream #(.MAX_D(MAX_D), .N_COEF(256), .OUT_BYTES(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .d_sel(dsel_a),
    .in_valid(iv_a), .in_ready(ir_a), .in_coef(coef_a),
    .out_valid(ov_a), .out_ready(or_a), .out_data(od_a), .out_last(last_a),
    .busy(busy_a), .done(done_a), .cfg_err(cerr_a)
`ifdef BYTE_ENCODE_RANGE_CHECK_EN
    , .range_err(rerr_a)
`endif
  );

  byte_encode_stream #(.MAX_D(MAX_D), .N_COEF(256), .OUT_BYTES(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .d_sel(dsel_b),
    .in_valid(iv_b), .in_ready(ir_b), .in_coef(coef_b),
    .out_valid(ov_b), .out_ready(or_b), .out_data(od_b), .out_last(last_b),
    .busy(busy_b), .done(done_b), .cfg_err(cerr_b)
`ifdef BYTE_ENCODE_RANGE_CHECK_EN
    , .range_err(rerr_b)
`endif
  );

  int unsigned  total = 0;
  int unsigned  bad   = 0;
  int unsigned  cq[$];
  logic [255:0] exp_q[$];
  logic [255:0] got_q[$];
  logic         got_last[$];

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Reference: flatten every coefficient into its d bits, LSB first, then cut into beats.
  function automatic void model(input int d, input int ob);
    bit           bits[$];
    logic [255:0] v;
    exp_q.delete();
    foreach (cq[i])
      for (int b = 0; b < d; b++) bits.push_back(((cq[i] >> b) & 1) != 0);
    for (int k = 0; k < bits.size() / (8 * ob); k++) begin
      v = '0;
      for (int j = 0; j < 8 * ob; j++) v[j] = bits[k * 8 * ob + j];
      exp_q.push_back(v);
    end
  endfunction

  task automatic compare(input string tag, input int d, input int ob);
    model(d, ob);
    chk({tag, "_nbeats"}, got_q.size(), (32 * d) / ob);
    foreach (exp_q[k]) begin
      if (k < got_q.size()) begin
        chk({tag, "_data"}, got_q[k], exp_q[k]);
        chk({tag, "_last"}, got_last[k], k == exp_q.size() - 1);
      end
    end
  endtask

  task automatic fill_random(input int max_val);
    cq.delete();
    for (int i = 0; i < 256; i++) cq.push_back($urandom_range(max_val));
  endtask

  task automatic run_a(input int d, input int vpct, input int rpct, input int stall_at,
                       input int restart_at, input int abort_at, input string tag);
    int         idx = 0;
    int         cyc = 0;
    int         hold = 0;
    logic       holding;
    logic       stalled = 1'b0;
    logic       fin = 1'b0;
    logic [7:0] prev = '0;
    got_q.delete();
    got_last.delete();
    @(negedge clk);
    start_a = 1'b1;
    dsel_a  = d[3:0];
    @(negedge clk);
    start_a = 1'b0;
    #1;
    chk({tag, "_busy"}, busy_a, 1'b1);
    while (!fin && cyc < 20000) begin
      if (abort_at > 0 && cyc == abort_at) break;
      start_a = (cyc == restart_at);
      dsel_a  = (cyc == restart_at) ? 4'd3 : dsel_a;
      iv_a    = (idx < cq.size()) && ($urandom_range(99) < vpct);
      coef_a  = (idx < cq.size()) ? MAX_D'(cq[idx]) : '0;
      holding = (stall_at >= 0) && (got_q.size() == stall_at) && (hold < 20);
      if (holding) begin
        or_a = 1'b0;
        hold++;
      end else begin
        or_a = ($urandom_range(99) < rpct);
      end
      #1;
      if (stalled && ov_a) chk({tag, "_stable"}, od_a, prev);
      if (holding && ov_a) chk({tag, "_stall_ir"}, ir_a, 1'b0);
      if (iv_a && ir_a) idx++;
      if (ov_a && or_a) begin
        got_q.push_back(od_a);
        got_last.push_back(last_a);
        if (last_a) fin = 1'b1;
      end
      stalled = ov_a && !or_a;
      prev    = od_a;
      cyc++;
      @(negedge clk);
    end
    iv_a    = 1'b0;
    or_a    = 1'b0;
    start_a = 1'b0;
    if (abort_at > 0 && !fin) return;
    if (!fin) begin
      chk({tag, "_timeout"}, 1'b1, 1'b0);
      return;
    end
    #1;
    chk({tag, "_done"}, done_a, 1'b1);
    chk({tag, "_idle"}, busy_a, 1'b0);
    @(negedge clk);
    #1;
    chk({tag, "_done_pulse"}, done_a, 1'b0);
    compare(tag, d, 1);
  endtask

  task automatic run_b(input string tag);
    int   idx = 0;
    int   cyc = 0;
    logic fin = 1'b0;
    got_q.delete();
    got_last.delete();
    @(negedge clk);
    start_b = 1'b1;
    dsel_b  = 4'd4;
    @(negedge clk);
    start_b = 1'b0;
    while (!fin && cyc < 5000) begin
      iv_b   = (idx < cq.size());
      coef_b = (idx < cq.size()) ? MAX_D'(cq[idx]) : '0;
      or_b   = 1'b1;
      #1;
      if (iv_b && ir_b) idx++;
      if (ov_b && or_b) begin
        got_q.push_back(od_b);
        got_last.push_back(last_b);
        if (last_b) fin = 1'b1;
      end
      cyc++;
      @(negedge clk);
    end
    iv_b = 1'b0;
    or_b = 1'b0;
    if (!fin) begin
      chk({tag, "_timeout"}, 1'b1, 1'b0);
      return;
    end
    #1;
    chk({tag, "_done"}, done_b, 1'b1);
    compare(tag, 4, 4);
  endtask

  task automatic cfg_bad(input logic [3:0] d, input string tag);
    @(negedge clk);
    start_a = 1'b1;
    dsel_a  = d;
    @(negedge clk);
    start_a = 1'b0;
    #1;
    chk({tag, "_cfg_err"}, cerr_a, 1'b1);
    chk({tag, "_busy"}, busy_a, 1'b0);
    @(negedge clk);
    #1;
    chk({tag, "_cfg_err_pulse"}, cerr_a, 1'b0);
    chk({tag, "_busy2"}, busy_a, 1'b0);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_ir"}, ir_a, 1'b0);
    chk({tag, "_ov"}, ov_a, 1'b0);
    chk({tag, "_busy"}, busy_a, 1'b0);
    chk({tag, "_done"}, done_a, 1'b0);
    chk({tag, "_cfg_err"}, cerr_a, 1'b0);
    chk({tag, "_data"}, od_a, 8'h00);
  endtask

  initial begin
    rst_n   = 1'b0;
    start_a = 1'b0; dsel_a = '0; iv_a = 1'b0; or_a = 1'b0; coef_a = '0;
    start_b = 1'b0; dsel_b = '0; iv_b = 1'b0; or_b = 1'b0; coef_b = '0;
    repeat (2) @(negedge clk);
    #1;
    chk_quiet("rst");
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk_quiet("idle");

    cq.delete();
    for (int i = 0; i < 256; i++) cq.push_back((i % 2 == 0) ? 1 : 0);
    run_a(1, 100, 100, -1, -1, -1, "d1");
    chk("d1_first", got_q[0], 8'h55);

    cq.delete();
    cq.push_back(12'h123);
    cq.push_back(12'h456);
    for (int i = 2; i < 256; i++) cq.push_back(0);
    run_a(12, 100, 100, -1, -1, -1, "d12");
    chk("d12_b0", got_q[0], 8'h23);
    chk("d12_b1", got_q[1], 8'h61);
    chk("d12_b2", got_q[2], 8'h45);

    fill_random(1023);
    run_a(10, 100, 100, 40, -1, -1, "bp");

    cfg_bad(4'd0, "d0");
    cfg_bad(4'd13, "d13");

    fill_random(63);
    run_a(6, 90, 90, -1, 50, -1, "restart");

    for (int r = 0; r < 4; r++) begin
      int d;
      d = $urandom_range(12, 1);
      fill_random(4095);
      run_a(d, 70, 60, -1, -1, -1, "rand");
    end

    fill_random(127);
    run_a(7, 100, 100, -1, -1, 100, "abort");
    rst_n = 1'b0;
    #1;
    chk_quiet("abort_rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      chk("abort_no_done", done_a, 1'b0);
    end
    fill_random(31);
    run_a(5, 80, 80, -1, -1, -1, "after_abort");

`ifdef BYTE_ENCODE_RANGE_CHECK_EN
    fill_random(15);
    cq[0] = 32'h1F;
    run_a(4, 100, 100, -1, -1, -1, "range");
    chk("range_err_set", rerr_a, 1'b1);
    chk("range_nibble", got_q[0][3:0], 4'hF);
    fill_random(15);
    run_a(4, 100, 100, -1, -1, -1, "range_clr");
    chk("range_err_clr", rerr_a, 1'b0);
`endif

    cq.delete();
    for (int i = 0; i < 256; i++) cq.push_back((i + 1) % 16);
    run_b("ob4");
    chk("ob4_b0", got_q[0], 32'h87654321);
    chk("ob4_b1", got_q[1], 32'h0FEDCBA9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
